// File: rtl/datareg_pkg.sv
// Shared op encodings and widths for the datareg_bank register file.
package datareg_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
  localparam logic [OP_W-1:0] OP_INC  = 2'b01;
  localparam logic [OP_W-1:0] OP_DEC  = 2'b10;
  localparam logic [OP_W-1:0] OP_CLR  = 2'b11;

  // Only INC and DEC can produce a nonzero carry/borrow.
  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/datareg_op.sv
// Combinational in-place write op: load, increment, decrement or clear one register value.
module datareg_op
  import datareg_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] wdata,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] inc_sum;

  // Extra top bit of the widened sum is the increment carry-out.
  assign inc_sum = {1'b0, cur} + (WIDTH+1)'(1);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_LOAD: result = wdata;
      OP_INC: begin
        result = inc_sum[WIDTH-1:0];
        carry  = inc_sum[WIDTH];
      end
      OP_DEC: begin
        result = cur - WIDTH'(1);
        carry  = (cur == '0);
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/datareg_bank.sv
// Bank of NREGS data registers with one op write port, two registered read ports and carry/zero flags.
// Build option: define DATAREG_BYPASS_EN for write-through on same-cycle read/write collisions.
module datareg_bank
  import datareg_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [$clog2(NREGS)-1:0]  waddr_i,
  input  logic [OP_W-1:0]           wop_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [$clog2(NREGS)-1:0]  ra_addr_i,
  input  logic [$clog2(NREGS)-1:0]  rb_addr_i,
  output logic [WIDTH-1:0]          ra_o,
  output logic [WIDTH-1:0]          rb_o,
  output logic                      carry_o,
  output logic                      zero_o
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];

  logic             waddr_ok;
  logic             ra_ok;
  logic             rb_ok;
  logic             wr_en;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Index range checks only matter for non-power-of-2 NREGS.
  assign waddr_ok = ({1'b0, waddr_i}   < (AW+1)'(NREGS));
  assign ra_ok    = ({1'b0, ra_addr_i} < (AW+1)'(NREGS));
  assign rb_ok    = ({1'b0, rb_addr_i} < (AW+1)'(NREGS));
  assign wr_en    = we_i && waddr_ok;

  always_comb begin
    cur = '0;
    if (waddr_ok) cur = regs[waddr_i];
  end

  datareg_op #(
    .WIDTH (WIDTH)
  ) u_op (
    .cur    (cur),
    .wdata  (wdata_i),
    .op     (wop_i),
    .result (result),
    .carry  (carry)
  );

  // Read muxes; with the bypass build a colliding write is forwarded.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (ra_ok) rd_a = regs[ra_addr_i];
    if (rb_ok) rd_b = regs[rb_addr_i];
`ifdef DATAREG_BYPASS_EN
    if (wr_en && (ra_addr_i == waddr_i)) rd_a = result;
    if (wr_en && (rb_addr_i == waddr_i)) rd_b = result;
`else
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr_i] <= result;
    end
  end

  // Flags describe the last accepted write and hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_o <= 1'b0;
      zero_o  <= 1'b1;
    end else if (wr_en) begin
      carry_o <= carry && op_is_arith(wop_i);
      zero_o  <= (result == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ra_o <= '0;
      rb_o <= '0;
    end else begin
      ra_o <= rd_a;
      rb_o <= rd_b;
    end
  end

endmodule
